// File: rtl/state_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : state_sequencer
// Brief    : CDECv control-step sequencer; fetch/dispatch/execute stepping,
//            HALT/reset hold, cycle and instruction counters.
// Revision : 1.0 - initial release
// ============================================================================
module state_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cc_en,
    input  logic        run,
    input  logic [7:0]  ird,
    input  logic        end_sq,
    input  logic        pause_cc,
    output logic [11:0] state,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] cycle_cnt,
    output logic [15:0] instr_cnt
);

    localparam logic [11:0] c_st_r    = 12'h000;
    localparam logic [11:0] c_st_f0   = 12'h010;
    localparam logic [11:0] c_st_f1   = 12'h011;
    localparam logic [11:0] c_st_f2   = 12'h012;
    localparam logic [11:0] c_st_halt = 12'hFF0;

    logic [11:0] r_state;
    logic        r_illegal;
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_instr_cnt;

    logic [11:0] w_next;
    logic [7:0]  w_cls;
    logic        w_cls_ok;
    logic        w_set_illegal;
    logic        w_hold;
    logic        w_unused;

    // Only the opcode nibble selects the class; operand bits belong to the decoder.
    assign w_unused = &{1'b0, ird[3:0]};

    always_comb begin
        w_cls    = 8'h00;
        w_cls_ok = 1'b1;
        case (ird[7:4])
            4'h1:    w_cls = 8'h10;
            4'h2:    w_cls = 8'h11;
            4'h3:    w_cls = 8'h12;
            4'h8:    w_cls = 8'h20;
            4'h9:    w_cls = 8'h21;
            4'hA:    w_cls = 8'h22;
            4'hB:    w_cls = 8'h23;
            4'hC:    w_cls = 8'h24;
            4'hD:    w_cls = 8'h25;
            4'hE:    w_cls = 8'h26;
            4'hF:    w_cls = 8'hFF;
            default: w_cls_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_hold        = pause_cc & ~run;
        if (pause_cc) begin
            w_next = run ? c_st_f0 : r_state;
        end else if (end_sq) begin
            w_next = c_st_f0;
        end else begin
            case (r_state)
                c_st_f0: w_next = c_st_f1;
                c_st_f1: w_next = c_st_f2;
                c_st_f2: begin
                    if (w_cls_ok) begin
                        w_next = {w_cls, 4'h0};
                    end else begin
                        w_next        = c_st_f0;
                        w_set_illegal = 1'b1;
                    end
                end
                default: begin
                    // Runaway guard: a decoder that never ends the step chain restarts fetch.
                    if (r_state[3:0] == 4'hF) begin
                        w_next = c_st_f0;
                    end else begin
                        w_next = {r_state[11:4], r_state[3:0] + 4'd1};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_r;
            r_illegal   <= 1'b0;
            r_cycle_cnt <= 16'h0000;
            r_instr_cnt <= 16'h0000;
        end else if (cc_en) begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (!w_hold) begin
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
                if (w_next == c_st_f0) begin
                    r_instr_cnt <= r_instr_cnt + 16'd1;
                end
            end
        end
    end

    assign state     = r_state;
    assign halted    = (r_state == c_st_halt);
    assign illegal   = r_illegal;
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_state_sequencer
// Brief    : Directed + randomized bench for state_sequencer; the bench plays
//            the decoder and tracks an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_state_sequencer;

    logic        clk = 1'b0;
    logic        reset, cc_en, run, end_sq, pause_cc;
    logic [7:0]  ird;
    logic [11:0] state;
    logic        halted, illegal;
    logic [15:0] cycle_cnt, instr_cnt;

    always #5 clk = ~clk;

    state_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cc_en     (cc_en),
        .run       (run),
        .ird       (ird),
        .end_sq    (end_sq),
        .pause_cc  (pause_cc),
        .state     (state),
        .halted    (halted),
        .illegal   (illegal),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    localparam int P_R = 0, P_F0 = 1, P_F1 = 2, P_F2 = 3, P_EXEC = 4, P_HALT = 5;

    int          n_vec = 0;
    int          n_err = 0;
    int          m_phase;
    logic [7:0]  m_cls;
    int          m_step;
    int          m_last;
    bit          m_ill;
    logic [15:0] m_cyc, m_ins;

    // Opcode table: class byte and total instruction length (F0..end step).
    function automatic bit op_info(input logic [3:0] op, output logic [7:0] cls, output int len);
        cls = 8'h00; len = 0;
        case (op)
            4'h1: begin cls = 8'h10; len = 4; end
            4'h2: begin cls = 8'h11; len = 8; end
            4'h3: begin cls = 8'h12; len = 8; end
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
                cls = 8'h20 + {4'h0, op - 4'h8}; len = 6;
            end
            4'hF: begin cls = 8'hFF; len = 3; end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic logic [11:0] m_state();
        case (m_phase)
            P_F0:    return 12'h010;
            P_F1:    return 12'h011;
            P_F2:    return 12'h012;
            P_EXEC:  return {m_cls, 4'(m_step)};
            P_HALT:  return 12'hFF0;
            default: return 12'h000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("state", {4'h0, state}, {4'h0, m_state()});
        check("halted", {15'h0, halted}, {15'h0, (m_phase == P_HALT)});
        check("illegal", {15'h0, illegal}, {15'h0, m_ill});
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("instr_cnt", instr_cnt, m_ins);
    endtask

    task automatic tick(input bit rs, input bit en, input bit rn, input logic [7:0] ir, input bit chk);
        logic [7:0] cls;
        int         len;
        bit         ok;
        bit         to_f0;
        reset    = rs;
        cc_en    = en;
        run      = rn;
        ird      = ir;
        pause_cc = (m_phase == P_R) || (m_phase == P_HALT);
        end_sq   = (m_phase == P_HALT) || (m_phase == P_EXEC && m_step == m_last);
        @(posedge clk);
        if (rs) begin
            m_phase = P_R; m_ill = 1'b0; m_cyc = '0; m_ins = '0;
        end else if (en && !(pause_cc && !rn)) begin
            m_cyc++;
            to_f0 = 1'b0;
            if (pause_cc || end_sq) begin
                to_f0 = 1'b1;
            end else begin
                case (m_phase)
                    P_F0: m_phase = P_F1;
                    P_F1: m_phase = P_F2;
                    P_F2: begin
                        ok = op_info(ir[7:4], cls, len);
                        if (!ok) begin
                            m_ill = 1'b1; to_f0 = 1'b1;
                        end else if (cls == 8'hFF) begin
                            m_phase = P_HALT;
                        end else begin
                            m_phase = P_EXEC; m_cls = cls; m_step = 0; m_last = len - 4;
                        end
                    end
                    default: begin
                        if (m_step == 15) to_f0 = 1'b1;
                        else m_step++;
                    end
                endcase
            end
            if (to_f0) begin
                m_phase = P_F0;
                m_ins++;
            end
        end
        #1;
        if (chk) check_all();
    endtask

    // Step from F0 until fetch restarts or HALT is reached.
    task automatic run_instr(input logic [7:0] ir);
        int n = 0;
        do begin
            tick(1'b0, 1'b1, 1'b0, ir, 1'b1);
            n++;
        end while (!(m_phase == P_F0 || m_phase == P_HALT) && n < 20);
        check("instr_bound", 16'(n < 20), 16'h1);
    endtask

    initial begin
        logic [15:0] c0;
        m_phase = P_R; m_ill = 0; m_cyc = 0; m_ins = 0; m_cls = 0; m_step = 0; m_last = 0;
        reset = 1; cc_en = 1; run = 0; ird = 0; end_sq = 0; pause_cc = 1;

        tick(1, 1, 0, 8'h00, 1);
        repeat (5) tick(0, 1, 0, 8'h00, 1);
        check("idle_cyc", cycle_cnt, 16'h0000);
        tick(0, 1, 1, 8'h00, 1);
        check("run_f0", {4'h0, state}, 16'h0010);
        check("run_ins", instr_cnt, 16'h0001);

        // MOV A,B: 010 011 012 100 010
        c0 = m_cyc;
        tick(0, 1, 0, 8'h15, 1);
        tick(0, 1, 0, 8'h15, 1);
        tick(0, 1, 0, 8'h15, 1);
        check("mov_exec", {4'h0, state}, 16'h0100);
        tick(0, 1, 0, 8'h15, 1);
        check("mov_len", cycle_cnt - c0, 16'd4);

        run_instr(8'h81);
        run_instr(8'h21);
        run_instr(8'h50);
        check("ill_set", {15'h0, illegal}, 16'h0001);
        run_instr(8'h9A);
        run_instr(8'h3C);
        check("ill_sticky", {15'h0, illegal}, 16'h0001);

        run_instr(8'hF0);
        check("halt_state", {4'h0, state}, 16'h0FF0);
        c0 = m_cyc;
        repeat (10) tick(0, 1, 0, 8'h00, 1);
        check("halt_cyc", cycle_cnt, c0);
        tick(0, 1, 1, 8'h00, 1);

        // ADD with a 3-cycle cc_en gap in the middle
        repeat (4) tick(0, 1, 0, 8'h81, 1);
        c0 = m_cyc;
        repeat (3) tick(0, 0, 1, 8'h81, 1);
        check("frozen_cyc", cycle_cnt, c0);
        tick(0, 1, 0, 8'h81, 1);
        tick(1, 0, 0, 8'h81, 1);
        check("rst_nocc", cycle_cnt, 16'h0000);

        // run held high in R exits once only
        repeat (4) tick(0, 1, 1, 8'h15, 1);

        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(99) == 0), ($urandom_range(7) != 0),
                 ($urandom_range(3) == 0), 8'($urandom), 1);
        end

        tick(1, 1, 0, 8'h00, 1);
        tick(0, 1, 1, 8'h00, 1);
        for (int i = 0; i < 70000 && m_cyc != 16'hFFFF; i++) tick(0, 1, 0, 8'h81, 0);
        check_all();
        check("pre_wrap", cycle_cnt, 16'hFFFF);
        tick(0, 1, 0, 8'h81, 1);
        check("wrap", cycle_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
